// File: rtl/rsa_if_pkg.sv
// Shared definitions for the ARM command/data protocol: widths, command codes, responder states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package rsa_if_pkg;

    localparam int RSA_DATA_W = 1024;
    localparam int RSA_CMD_W  = 32;

    // Command codes carried on arm_to_fpga_cmd
    localparam int CMD_COMPUTE_MONT = 1;
    localparam int CMD_READ_MOD     = 2;
    localparam int CMD_READ_RSQ     = 3;
    localparam int CMD_READ_EXP     = 4;
    localparam int CMD_WRITE        = 5;
    localparam int CMD_COMPUTE_EXP  = 6;

    // Responder states; the encoding doubles as the leds[2:0] status code
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_DATA = 3'd1,
        ST_START   = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_TX_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/rsa_arm_responder.sv
// ARM-facing command responder: decodes commands, moves operands to the cores, returns results.
// Latency: outputs registered; done rises the cycle after the finishing handshake or core_done.
// Backpressure: input ready held until ARM valid; output valid held until ARM ready; done held until done_read.
module rsa_arm_responder
    import rsa_if_pkg::*;
#(
    parameter int DATA_W = RSA_DATA_W,
    parameter int CMD_W  = RSA_CMD_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
    input  logic              arm_to_fpga_cmd_valid,
    output logic              fpga_to_arm_done,
    input  logic              fpga_to_arm_done_read,
    input  logic              arm_to_fpga_data_valid,
    output logic              arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0] arm_to_fpga_data,
    output logic              fpga_to_arm_data_valid,
    input  logic              fpga_to_arm_data_ready,
    output logic [DATA_W-1:0] fpga_to_arm_data,
    output logic [DATA_W-1:0] op_data,
    output logic              op_load_mod,
    output logic              op_load_rsq,
    output logic              op_load_exp,
    output logic              core_start_mont,
    output logic              core_start_exp,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic [3:0]        leds
);

    state_t            state;
    logic [2:0]        cmd_q;     // low bits of the latched command select the load pulse
    logic [DATA_W-1:0] result_q;
    logic              bad_cmd;

    assign fpga_to_arm_data = result_q;
    assign leds             = {bad_cmd, state};

    // Command FSM with registered handshake outputs and one-cycle strobes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                  <= ST_IDLE;
            cmd_q                  <= 3'd0;
            result_q               <= '0;
            op_data                <= '0;
            bad_cmd                <= 1'b0;
            fpga_to_arm_done       <= 1'b0;
            arm_to_fpga_data_ready <= 1'b0;
            fpga_to_arm_data_valid <= 1'b0;
            op_load_mod            <= 1'b0;
            op_load_rsq            <= 1'b0;
            op_load_exp            <= 1'b0;
            core_start_mont        <= 1'b0;
            core_start_exp         <= 1'b0;
        end else begin
            // Strobes last exactly one cycle unless re-asserted below
            op_load_mod     <= 1'b0;
            op_load_rsq     <= 1'b0;
            op_load_exp     <= 1'b0;
            core_start_mont <= 1'b0;
            core_start_exp  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (arm_to_fpga_cmd_valid) begin
                        cmd_q <= arm_to_fpga_cmd[2:0];
                        case (arm_to_fpga_cmd)
                            CMD_W'(CMD_READ_MOD),
                            CMD_W'(CMD_READ_RSQ),
                            CMD_W'(CMD_READ_EXP): begin
                                state                  <= ST_RX_DATA;
                                arm_to_fpga_data_ready <= 1'b1;
                            end
                            CMD_W'(CMD_COMPUTE_MONT): begin
                                state           <= ST_START;
                                core_start_mont <= 1'b1;
                            end
                            CMD_W'(CMD_COMPUTE_EXP): begin
                                state          <= ST_START;
                                core_start_exp <= 1'b1;
                            end
                            CMD_W'(CMD_WRITE): begin
                                state                  <= ST_TX_DATA;
                                fpga_to_arm_data_valid <= 1'b1;
                            end
                            default: begin
                                // Unknown command completes immediately and is flagged until reset
                                state            <= ST_DONE;
                                fpga_to_arm_done <= 1'b1;
                                bad_cmd          <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_RX_DATA: begin
                    if (arm_to_fpga_data_valid && arm_to_fpga_data_ready) begin
                        op_data                <= arm_to_fpga_data;
                        arm_to_fpga_data_ready <= 1'b0;
                        case (cmd_q)
                            3'(CMD_READ_MOD): op_load_mod <= 1'b1;
                            3'(CMD_READ_RSQ): op_load_rsq <= 1'b1;
                            default:          op_load_exp <= 1'b1;
                        endcase
                        state            <= ST_DONE;
                        fpga_to_arm_done <= 1'b1;
                    end
                end

                // Start strobe was raised on entry; it has now been high for one cycle
                ST_START: state <= ST_COMPUTE;

                ST_COMPUTE: begin
                    if (core_done) begin
                        result_q         <= core_result;
                        state            <= ST_DONE;
                        fpga_to_arm_done <= 1'b1;
                    end
                end

                ST_TX_DATA: begin
                    if (fpga_to_arm_data_valid && fpga_to_arm_data_ready) begin
                        fpga_to_arm_data_valid <= 1'b0;
                        state                  <= ST_DONE;
                        fpga_to_arm_done       <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (fpga_to_arm_done_read) begin
                        fpga_to_arm_done <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_arm_responder.sv
module tb_rsa_arm_responder;
    import rsa_if_pkg::*;

    localparam int DW = 1024;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic [CW-1:0] arm_to_fpga_cmd;
    logic          arm_to_fpga_cmd_valid;
    logic          fpga_to_arm_done;
    logic          fpga_to_arm_done_read;
    logic          arm_to_fpga_data_valid;
    logic          arm_to_fpga_data_ready;
    logic [DW-1:0] arm_to_fpga_data;
    logic          fpga_to_arm_data_valid;
    logic          fpga_to_arm_data_ready;
    logic [DW-1:0] fpga_to_arm_data;
    logic [DW-1:0] op_data;
    logic          op_load_mod, op_load_rsq, op_load_exp;
    logic          core_start_mont, core_start_exp;
    logic          core_done;
    logic [DW-1:0] core_result;
    logic [3:0]    leds;

    rsa_arm_responder dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .op_data                (op_data),
        .op_load_mod            (op_load_mod),
        .op_load_rsq            (op_load_rsq),
        .op_load_exp            (op_load_exp),
        .core_start_mont        (core_start_mont),
        .core_start_exp         (core_start_exp),
        .core_done              (core_done),
        .core_result            (core_result),
        .leds                   (leds)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] exp_q[$];     // scoreboard of expected wide values
    logic [DW-1:0] exp_w;
    logic [DW-1:0] last_result;  // model of the result register

    logic [DW-1:0] d_rsq, d_mod, r_mont, r_exp, r_stray;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h (upper bits %s)",
                    tag, obs[63:0], expv[63:0], (obs[DW-1:64] === expv[DW-1:64]) ? "equal" : "differ");
    endtask

    task automatic pop_exp(input string tag, output logic [DW-1:0] v);
        total_cnt++;
        assert (exp_q.size() > 0) pass_cnt++;
        else $error("FAIL %s observed=empty-queue expected=entry", tag);
        v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    endtask

    task automatic send_cmd(input int c);
        arm_to_fpga_cmd       = CW'(c);
        arm_to_fpga_cmd_valid = 1'b1;
        tick();
        arm_to_fpga_cmd_valid = 1'b0;
        arm_to_fpga_cmd       = '0;
    endtask

    // Acknowledge a pending done, bounded wait
    task automatic finish_done(input string tag);
        for (int n = 0; n < 50 && fpga_to_arm_done !== 1'b1; n++) tick();
        chk({tag, "_done_hi"}, 64'(fpga_to_arm_done), 64'd1);
        chk({tag, "_state_done"}, 64'(leds[2:0]), 64'd5);
        fpga_to_arm_done_read = 1'b1;
        tick();
        fpga_to_arm_done_read = 1'b0;
        chk({tag, "_done_lo"}, 64'(fpga_to_arm_done), 64'd0);
        chk({tag, "_state_idle"}, 64'(leds[2:0]), 64'd0);
    endtask

    // Drive one core completion after a given number of COMPUTE cycles
    task automatic core_finish(input string tag, input int cycles, input logic [DW-1:0] r);
        for (int n = 0; n < cycles - 1; n++) tick();
        chk({tag, "_no_early_done"}, 64'(fpga_to_arm_done), 64'd0);
        chk({tag, "_in_compute"}, 64'(leds[2:0]), 64'd3);
        core_done   = 1'b1;
        core_result = r;
        exp_q.push_back(r);
        last_result = r;
        tick();
        core_done   = 1'b0;
        core_result = '0;
        chk({tag, "_done_next"}, 64'(fpga_to_arm_done), 64'd1);
    endtask

    // WRITE command: read the result register back with ready held off briefly
    task automatic read_result(input string tag);
        send_cmd(CMD_WRITE);
        chk({tag, "_tx_state"}, 64'(leds[2:0]), 64'd4);
        chk({tag, "_tx_valid"}, 64'(fpga_to_arm_data_valid), 64'd1);
        pop_exp({tag, "_sb"}, exp_w);
        chkw({tag, "_tx_data"}, fpga_to_arm_data, exp_w);
        tick(); tick();
        chk({tag, "_valid_held"}, 64'(fpga_to_arm_data_valid), 64'd1);
        fpga_to_arm_data_ready = 1'b1;
        tick();
        fpga_to_arm_data_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(fpga_to_arm_data_valid), 64'd0);
        finish_done(tag);
    endtask

    // Operand load command followed by one data transfer
    task automatic load_operand(input string tag, input int c, input logic [DW-1:0] d);
        send_cmd(c);
        chk({tag, "_rx_state"}, 64'(leds[2:0]), 64'd1);
        for (int n = 0; n < 3; n++) tick();
        chk({tag, "_ready_wait"}, 64'(arm_to_fpga_data_ready), 64'd1);
        arm_to_fpga_data       = d;
        arm_to_fpga_data_valid = 1'b1;
        exp_q.push_back(d);
        tick();
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '0;
        chk({tag, "_ready_drop"}, 64'(arm_to_fpga_data_ready), 64'd0);
        chk({tag, "_load_pulse"}, {61'd0, op_load_mod, op_load_rsq, op_load_exp},
            (c == CMD_READ_MOD) ? 64'b100 : (c == CMD_READ_RSQ) ? 64'b010 : 64'b001);
        pop_exp({tag, "_sb"}, exp_w);
        chkw({tag, "_op_data"}, op_data, exp_w);
        tick();
        chk({tag, "_pulse_end"}, {61'd0, op_load_mod, op_load_rsq, op_load_exp}, 64'd0);
        chkw({tag, "_op_stable"}, op_data, exp_w);
        finish_done(tag);
    endtask

    initial begin
        d_rsq   = {16'hDA8F, {62{16'h5A5A}}, 16'hE33C};
        d_mod   = {16'hC0DE, {62{16'h1234}}, 16'hBEEF};
        r_mont  = {512'd0, 16'h1AD6, {30{16'h3C3C}}, 16'h1F33};
        r_exp   = {512'd0, 16'hBDB2, {30{16'h7E7E}}, 16'h0189};
        r_stray = {DW{1'b1}};
        last_result = '0;

        resetn                 = 1'b0;
        arm_to_fpga_cmd        = '0;
        arm_to_fpga_cmd_valid  = 1'b0;
        fpga_to_arm_done_read  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '0;
        fpga_to_arm_data_ready = 1'b0;
        core_done              = 1'b0;
        core_result            = '0;

        // Reset state
        #25;
        chk("rst_outs", {56'd0, fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
                         op_load_mod, op_load_rsq, op_load_exp, core_start_mont, core_start_exp}, 64'd0);
        chk("rst_leds", 64'(leds), 64'd0);
        chkw("rst_result", fpga_to_arm_data, '0);
        chkw("rst_opdata", op_data, '0);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_idle", 64'(leds), 64'd0);

        // Operand load (R^2)
        load_operand("rsq", CMD_READ_RSQ, d_rsq);

        // Montgomery multiply then readback
        send_cmd(CMD_COMPUTE_MONT);
        chk("mont_start", {62'd0, core_start_mont, core_start_exp}, 64'b10);
        chk("mont_state", 64'(leds[2:0]), 64'd2);
        tick();
        chk("mont_start_end", {62'd0, core_start_mont, core_start_exp}, 64'd0);
        core_finish("mont", 20, r_mont);
        chkw("mont_result", fpga_to_arm_data, last_result);
        finish_done("mont");
        read_result("wr1");

        // Stray core_done in IDLE must not touch the result register
        core_done   = 1'b1;
        core_result = r_stray;
        tick();
        core_done   = 1'b0;
        core_result = '0;
        chk("stray_idle", 64'(leds), 64'd0);
        chkw("stray_result", fpga_to_arm_data, last_result);

        // Exponentiation then readback
        send_cmd(CMD_COMPUTE_EXP);
        chk("exp_start", {62'd0, core_start_mont, core_start_exp}, 64'b01);
        tick();
        core_finish("exp", 12, r_exp);
        finish_done("exp");
        read_result("wr2");

        // Unknown command
        send_cmd(7);
        chk("bad_no_pulse", {59'd0, op_load_mod, op_load_rsq, op_load_exp, core_start_mont, core_start_exp}, 64'd0);
        chk("bad_done", 64'(fpga_to_arm_done), 64'd1);
        chk("bad_flag", 64'(leds[3]), 64'd1);
        // done_read and a command in the same cycle: command is dropped
        fpga_to_arm_done_read = 1'b1;
        arm_to_fpga_cmd       = CW'(CMD_READ_MOD);
        arm_to_fpga_cmd_valid = 1'b1;
        tick();
        fpga_to_arm_done_read = 1'b0;
        arm_to_fpga_cmd_valid = 1'b0;
        arm_to_fpga_cmd       = '0;
        chk("same_cycle_idle", 64'(leds[2:0]), 64'd0);
        tick();
        chk("same_cycle_no_rx", 64'(arm_to_fpga_data_ready), 64'd0);
        load_operand("exp_ld", CMD_READ_EXP, d_mod);
        chk("bad_flag_sticky", 64'(leds[3]), 64'd1);

        // Reset during COMPUTE
        send_cmd(CMD_COMPUTE_MONT);
        tick(); tick();
        chk("pre_rst_compute", 64'(leds[2:0]), 64'd3);
        resetn = 1'b0;
        #1;
        chk("rst_compute_outs", {61'd0, fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid}, 64'd0);
        chk("rst_compute_leds", 64'(leds), 64'd0);
        chkw("rst_compute_result", fpga_to_arm_data, '0);
        last_result = '0;
        tick();
        resetn = 1'b1;
        core_done   = 1'b1;
        core_result = r_stray;
        tick();
        core_done   = 1'b0;
        core_result = '0;
        tick();
        chk("late_core_done_done", 64'(fpga_to_arm_done), 64'd0);
        chkw("late_core_done_result", fpga_to_arm_data, last_result);

        // Reset during DONE
        send_cmd(7);
        chk("pre_rst_done", 64'(fpga_to_arm_done), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_done_outs", 64'(fpga_to_arm_done), 64'd0);
        chk("rst_done_leds", 64'(leds), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        load_operand("mod", CMD_READ_MOD, d_mod);
        chk("final_flag_clear", 64'(leds[3]), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard stop so the run can never hang
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rsa_arm_responder.md
Name: rsa_arm_responder

Overview:
FPGA-side responder for the ARM command/data protocol: accepts 32-bit commands, receives 1024-bit operands, starts the Montgomery/exponentiation cores, returns results and raises the done handshake. Sits between the ARM-facing ports of the top-level wrapper and the core datapath. Holds only the last captured input word and the result register; operand storage lives in the cores.

Parameters:
DATA_W, 1024, width of data words on both directions
CMD_W, 32, command word width

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
arm_to_fpga_cmd  in  CMD_W  command word
arm_to_fpga_cmd_valid  in  1  command strobe, one cycle
fpga_to_arm_done  out  1  operation complete, held until read
fpga_to_arm_done_read  in  1  ARM acknowledges done
arm_to_fpga_data_valid  in  1  ARM input data valid
arm_to_fpga_data_ready  out  1  responder ready to take input data
arm_to_fpga_data  in  DATA_W  input data
fpga_to_arm_data_valid  out  1  output data valid
fpga_to_arm_data_ready  in  1  ARM ready for output data
fpga_to_arm_data  out  DATA_W  output data (result register)
op_data  out  DATA_W  captured input word to cores
op_load_mod  out  1  pulse: load modulus (cmd 2)
op_load_rsq  out  1  pulse: load R^2 mod m / A,B (cmd 3)
op_load_exp  out  1  pulse: load R mod m / exponent (cmd 4)
core_start_mont  out  1  pulse: start Montgomery multiply (cmd 1)
core_start_exp  out  1  pulse: start exponentiation (cmd 6)
core_done  in  1  core finished, one-cycle pulse
core_result  in  DATA_W  core result, valid with core_done
leds  out  4  status: [2:0] state code, [3] sticky bad-command flag

Behaviour:
- Reset (async, resetn=0): state IDLE; every output 0; op_data, result register, leds cleared. Reset mid-operation aborts immediately, no done issued.
- Commands: 1 MONT, 2 READ_MOD, 3 READ_RSQ, 4 READ_EXP, 5 WRITE, 6 EXP. cmd_valid sampled only in IDLE; ignored in every other state.
- IDLE: on cmd_valid latch command. 2/3/4 -> RX_DATA; 1/6 -> START; 5 -> TX_DATA; others -> DONE with leds[3] set (sticky until reset).
- RX_DATA: arm_to_fpga_data_ready=1. On data_valid&&ready: capture into op_data, ready drops next cycle, matching op_load_* pulses 1 cycle with op_data stable, then -> DONE. ready stays high indefinitely until valid.
- START: core_start_mont or core_start_exp high exactly 1 cycle -> COMPUTE.
- COMPUTE: wait core_done; capture core_result into result register same edge -> DONE. core_done outside COMPUTE ignored; result register unchanged.
- TX_DATA: fpga_to_arm_data_valid=1, data = result register. On valid&&ready: valid drops next cycle -> DONE. WRITE before any compute returns 0. Result register persists across commands.
- DONE: fpga_to_arm_done=1 from the cycle after the finishing event; held until done_read sampled high; done=0 next cycle, -> IDLE. done_read outside DONE ignored. done_read and cmd_valid in same cycle: command ignored.
- fpga_to_arm_data always drives the result register; ready/valid outputs are registered.
- leds[2:0] state code: IDLE 0, RX_DATA 1, START 2, COMPUTE 3, TX_DATA 4, DONE 5.

Decomposition:
- Shared package rsa_if_pkg: command codes (CMD_COMPUTE_MONT=1 .. CMD_COMPUTE_EXP=6), state enum and codes, DATA_W/CMD_W constants; the top-level wrapper and benches import it.
- Single module, no sub-module; one state machine plus data/result registers.

Test Plan:
- Reset: hold resetn=0 25 ns -> all outputs 0, leds=0; release -> state IDLE.
- cmd 3 then data 1024'hDA8F...E33C -> ready high until valid, op_load_rsq one-cycle pulse with op_data=DA8F...E33C, done until done_read, then IDLE.
- cmd 1, core model returns core_done after 20 cycles with 512'h1AD6...1F33 -> core_start_mont single pulse, done one cycle after core_done; then cmd 5 -> fpga_to_arm_data=...1F33 with valid, valid drops after ready handshake, done asserted.
- cmd 6 with stray core_done in IDLE beforehand -> stray ignored, result only from in-COMPUTE core_done (512'hBDB2...0189).
- cmd 7 -> no load/start pulses, done asserted, leds[3]=1 and stays 1 through later valid commands.
- resetn low during COMPUTE and during DONE -> done/valid/ready drop immediately; later core_done ignored; new cmd 2 completes normally.
